mem_delay_port: RTL and testbench

- Parametrised memory-latency model between mips_core and a data memory instance.
- Generalises a fixed 4-stage flop delay chain:
  - configurable latency;
  - configurable lane count and width;
  - per-lane byte enables;
  - valid/ready request and response handshakes, so the core stalls instead of relying on hard-wired timing.
- Single outstanding transaction; memory is combinational-read, synchronous-write.

---
 rtl/mem_delay_pkg.sv | 29 ++
 rtl/mem_delay_timer.sv | 31 +++
 rtl/mem_delay_port.sv | 136 +++++++++++++
 tb/tb_mem_delay_port.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_delay_pkg.sv
// mem_delay_pkg: shared types and constants for the memory-latency port.
//   state_t                 FSM encoding (IDLE, WAIT, ISSUE, RESP)
//   LATENCY_MIN/MAX         legal LATENCY range
//   CNT_W                   latency counter width
//   lane_slice(word, idx)   extract one lane of a default-geometry word
package mem_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 255;
    localparam int CNT_W       = 8;

    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 8;

    function automatic logic [DEF_LANE_W-1:0] lane_slice(
        input logic [DEF_LANES*DEF_LANE_W-1:0] word,
        input int                              idx
    );
        return word[idx*DEF_LANE_W +: DEF_LANE_W];
    endfunction

endpackage

// File: rtl/mem_delay_timer.sv
// mem_delay_timer: loadable 8-bit down-counter with zero flag.
//   clk, rst_b   clock / async active-high reset
//   load         load load_val (wins over dec)
//   load_val     value to load
//   dec          decrement by one; holds at zero
//   zero         count == 0
module mem_delay_timer
    import mem_delay_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_delay_port.sv
// mem_delay_port: parametrised memory-latency model between the core and a
// combinational-read / synchronous-write data memory. One transaction in
// flight; request accepted in IDLE, issued to memory LATENCY cycles later,
// response held until consumed.
//   clk, rst_b                      clock / async active-high reset
//   req_valid/ready, req_we, req_addr, req_wdata, req_be   request channel
//   rsp_valid/ready, rsp_rdata      response channel
//   mem_addr, mem_wdata, mem_be, mem_we, mem_rdata          memory side
// Optional macro MEM_DELAY_PORT_STATS_EN adds saturating counters
// stat_reads, stat_writes, stat_stall_cycles.
module mem_delay_port
    import mem_delay_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LANES   = 4,
    parameter int LANE_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*LANE_W-1:0] req_wdata,
    input  logic [LANES-1:0]        req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LANES*LANE_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANES*LANE_W-1:0] mem_wdata,
    output logic [LANES-1:0]        mem_be,
    output logic                    mem_we,
    input  logic [LANES*LANE_W-1:0] mem_rdata
`ifdef MEM_DELAY_PORT_STATS_EN
    ,
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_stall_cycles
`endif
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_range
        $error("mem_delay_port: LATENCY must be within 1..255");
    end

    // Acceptance edge itself counts as one cycle and ISSUE is entered on the
    // edge where the counter is already zero, hence LATENCY-2.
    localparam logic [CNT_W-1:0] LOAD_VAL = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t           state;
    logic             we_q;
    logic [LANES-1:0] be_q;
    logic             cnt_zero;

    mem_delay_timer u_timer (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (state == IDLE && req_valid),
        .load_val (LOAD_VAL),
        .dec      (state == WAIT),
        .zero     (cnt_zero)
    );

    // mem_addr / mem_wdata double as the request latches, so they hold the
    // last accepted values outside ISSUE.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_we    <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    mem_addr  <= req_addr;
                    mem_wdata <= req_wdata;
                    we_q      <= req_we;
                    be_q      <= req_be;
                    req_ready <= 1'b0;
                    if (LATENCY == 1) begin
                        state  <= ISSUE;
                        mem_we <= req_we;
                        mem_be <= req_we ? req_be : '0;
                    end else begin
                        state  <= WAIT;
                    end
                end
                WAIT: if (cnt_zero) begin
                    state  <= ISSUE;
                    mem_we <= we_q;
                    mem_be <= we_q ? be_q : '0;
                end
                ISSUE: begin
                    // Capture happens on the same edge as the memory write,
                    // so writes return the pre-write contents.
                    rsp_rdata <= mem_rdata;
                    rsp_valid <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_be    <= '0;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_DELAY_PORT_STATS_EN
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            stat_reads        <= '0;
            stat_writes       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (state == ISSUE && !we_q && stat_reads != '1)
                stat_reads <= stat_reads + 1'b1;
            if (state == ISSUE && we_q && stat_writes != '1)
                stat_writes <= stat_writes + 1'b1;
            if (req_valid && !req_ready && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_delay_port.sv
// Directed bench for mem_delay_port: main instance at LATENCY=4 with a small
// memory model, plus LATENCY=1 and LATENCY=255 instances for timing only.
// Timing note: "k edges after acceptance" means the k-th rising edge after
// the edge that accepted the request; ISSUE is observed after edge L-1 and
// rsp_valid after edge L (i.e. during cycles E0+L and E0+L+1).
module tb_mem_delay_port;
    import mem_delay_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we;

    logic        v1, rdy1, rv1, mwe1;
    logic [31:0] rd1, ma1, mw1;
    logic [3:0]  mb1;
    logic        v255, rdy255, rv255, mwe255;
    logic [31:0] rd255, ma255, mw255;
    logic [3:0]  mb255;

`ifdef MEM_DELAY_PORT_STATS_EN
    logic [31:0] st_rd, st_wr, st_stall;
    logic [31:0] st_rd1, st_wr1, st_stall1, st_rd255, st_wr255, st_stall255;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_delay_port #(.LATENCY(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef MEM_DELAY_PORT_STATS_EN
        , .stat_reads(st_rd), .stat_writes(st_wr), .stat_stall_cycles(st_stall)
`endif
    );

    mem_delay_port #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst_b(rst_b),
        .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv1), .rsp_ready(1'b1), .rsp_rdata(rd1),
        .mem_addr(ma1), .mem_wdata(mw1), .mem_be(mb1),
        .mem_we(mwe1), .mem_rdata(32'hCAFE0001)
`ifdef MEM_DELAY_PORT_STATS_EN
        , .stat_reads(st_rd1), .stat_writes(st_wr1), .stat_stall_cycles(st_stall1)
`endif
    );

    mem_delay_port #(.LATENCY(255)) dut_l255 (
        .clk(clk), .rst_b(rst_b),
        .req_valid(v255), .req_ready(rdy255), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv255), .rsp_ready(1'b1), .rsp_rdata(rd255),
        .mem_addr(ma255), .mem_wdata(mw255), .mem_be(mb255),
        .mem_we(mwe255), .mem_rdata(32'hCAFE00FF)
`ifdef MEM_DELAY_PORT_STATS_EN
        , .stat_reads(st_rd255), .stat_writes(st_wr255), .stat_stall_cycles(st_stall255)
`endif
    );

    // Memory model: 16 words indexed by addr[3:0], byte-enabled writes.
    logic [31:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[3:0]][i*8 +: 8] <= lane_slice(mem_wdata, i);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        tick;
        pre_en = 1'b0;
    endtask

    // Present a request, let it be accepted, then scramble the inputs.
    task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_be = ~be;
    endtask

    // Called right after the accepting edge; returns edges until rsp_valid.
    task automatic wait_rsp(input int lat, output int k_seen, output int pulses,
                            output logic [3:0] iss_be, output logic [31:0] iss_addr,
                            output logic iss_we);
        k_seen = -1; pulses = 0; iss_be = '0; iss_addr = '0; iss_we = 1'b0;
        for (int k = 1; k <= lat + 8; k++) begin
            if (mem_we) pulses++;
            if (k == lat) begin iss_be = mem_be; iss_addr = mem_addr; iss_we = mem_we; end
            tick;
            if (rsp_valid) begin k_seen = k; break; end
        end
    endtask

    int          k_seen, pulses, ops, stalls;
    logic [3:0]  iss_be;
    logic [31:0] iss_addr;
    logic        iss_we;

    initial begin
        rst_b = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; rsp_ready = 1'b1; v1 = 1'b0; v255 = 1'b0;
        tick; tick;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be",    {28'd0, mem_be}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_b = 1'b0;
        preload(4'd0, 32'hDEADBEEF);
        preload(4'd1, 32'hAABBCCDD);
        preload(4'd2, 32'h55667788);
        preload(4'd3, 32'h01020304);

        // Read, LATENCY=4
        start(1'b0, 32'h10020100, 32'h12345678, 4'hF);
        chk("rd_busy", {31'd0, req_ready}, 32'd0);
        wait_rsp(4, k_seen, pulses, iss_be, iss_addr, iss_we);
        chk("rd_latency", k_seen, 32'd4);
        chk("rd_we_pulses", pulses, 32'd0);
        chk("rd_issue_addr", iss_addr, 32'h10020100);
        chk("rd_issue_be", {28'd0, iss_be}, 32'd0);
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        tick;
        chk("rd_done_ready", {31'd0, req_ready}, 32'd1);
        chk("rd_done_valid", {31'd0, rsp_valid}, 32'd0);

        // Partial write
        start(1'b1, 32'h10020101, 32'h11223344, 4'b0101);
        wait_rsp(4, k_seen, pulses, iss_be, iss_addr, iss_we);
        chk("wr_latency", k_seen, 32'd4);
        chk("wr_we_pulses", pulses, 32'd1);
        chk("wr_issue_we", {31'd0, iss_we}, 32'd1);
        chk("wr_issue_be", {28'd0, iss_be}, 32'h5);
        chk("wr_issue_wdata", mem_wdata, 32'h11223344);
        chk("wr_rdata_old", rsp_rdata, 32'hAABBCCDD);
        chk("wr_mem", mem[1], 32'hAA22CC44);
        tick;

        // Backpressure, second request waiting
        rsp_ready = 1'b0;
        start(1'b0, 32'h10020101, 32'h0, 4'hF);
        wait_rsp(4, k_seen, pulses, iss_be, iss_addr, iss_we);
        chk("bp_latency", k_seen, 32'd4);
        req_we = 1'b0; req_addr = 32'h10020100; req_be = 4'hF; req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hAA22CC44);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        chk("bp_consumed_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_consumed_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_not_accepted", mem_addr, 32'h10020101);
        tick;
        chk("bp_second_accepted", {31'd0, req_ready}, 32'd0);
        chk("bp_second_addr", mem_addr, 32'h10020100);
        req_valid = 1'b0; req_addr = 32'hFFFFFFFF;
        wait_rsp(4, k_seen, pulses, iss_be, iss_addr, iss_we);
        chk("bp_second_latency", k_seen, 32'd4);
        chk("bp_second_rdata", rsp_rdata, 32'hDEADBEEF);
        tick;

        // Write with no lanes enabled
        start(1'b1, 32'h00000003, 32'hFFFFFFFF, 4'b0000);
        wait_rsp(4, k_seen, pulses, iss_be, iss_addr, iss_we);
        chk("be0_latency", k_seen, 32'd4);
        chk("be0_we_pulses", pulses, 32'd1);
        chk("be0_issue_be", {28'd0, iss_be}, 32'd0);
        chk("be0_rdata", rsp_rdata, 32'h01020304);
        chk("be0_mem", mem[3], 32'h01020304);
        tick;

        // Reset during WAIT of a write
        start(1'b1, 32'h00000002, 32'h00000000, 4'hF);
        tick;
        rst_b = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        tick; tick;
        rst_b = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_we || rsp_valid) pulses++;
            tick;
        end
        chk("mid_rst_no_activity", pulses, 32'd0);
        chk("mid_rst_mem", mem[2], 32'h55667788);

        // LATENCY=1: ISSUE right after acceptance, response one edge later
        req_we = 1'b1; req_addr = 32'h5; req_wdata = 32'h0; req_be = 4'b1010; v1 = 1'b1;
        tick;
        v1 = 1'b0;
        chk("l1_issue_we", {31'd0, mwe1}, 32'd1);
        chk("l1_issue_be", {28'd0, mb1}, 32'hA);
        tick;
        chk("l1_rsp_valid", {31'd0, rv1}, 32'd1);
        chk("l1_rdata", rd1, 32'hCAFE0001);
        chk("l1_we_low", {31'd0, mwe1}, 32'd0);

        // LATENCY=255
        req_we = 1'b0; v255 = 1'b1;
        tick;
        v255 = 1'b0;
        k_seen = -1;
        for (int k = 1; k <= 300; k++) begin
            tick;
            if (rv255) begin k_seen = k; break; end
        end
        chk("l255_latency", k_seen, 32'd255);
        chk("l255_rdata", rd255, 32'hCAFE00FF);
        tick;

`ifdef MEM_DELAY_PORT_STATS_EN
        rst_b = 1'b1; tick; rst_b = 1'b0;
        chk("st_rst_reads", st_rd, 32'd0);
        ops = 0; stalls = 0; rsp_ready = 1'b1;
        req_we = 1'b0; req_addr = 32'h0; req_be = 4'hF; req_wdata = 32'h0; req_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && ops < 5; cyc++) begin
            if (req_ready) begin
                tick;
                ops++;
                // op sequence: R, W, R, W, R
                req_we = (ops == 1 || ops == 3);
                req_addr = 32'(ops + 8);
                if (ops == 5) req_valid = 1'b0;
            end else begin
                stalls++;
                tick;
            end
        end
        for (int i = 0; i < 20 && !req_ready; i++) tick;
        chk("st_reads", st_rd, 32'd3);
        chk("st_writes", st_wr, 32'd2);
        chk("st_stall_hand", st_stall, 32'd20);
        chk("st_stall_counted", st_stall, stalls);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
